// File: rtl/uart_tx_pkg.sv
// Shared definitions for the MIDI/UART transmitter: state encoding and bit-period constants.
package uart_tx_pkg;

    // Numbering matches the receiver where the states correspond.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        DATA  = 3'b011,
        STOP  = 3'b100
    } tx_state_t;

    // 31250 baud from the system clock.
    localparam int unsigned MIDI_CLKS_PER_BIT   = 3200;
    localparam int unsigned MIDI_CLKS_PER_BIT_W = 12;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a source and the transmitter's holding register.
interface uart_tx_if;
    logic       dv;
    logic [7:0] pi;
    logic       rdy;

    modport master (output dv, output pi, input rdy);
    modport slave  (input dv, input pi, output rdy);
endinterface

// File: rtl/uart_tx_up_cnt_mod.sv
// Modulo up-counter with synchronous clear, clock enable and wrap carry.
module up_cnt_mod #(
    parameter int unsigned MODULO = 8,
    parameter int unsigned W      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         carry
);

    assign carry = ce & (cnt == W'(MODULO - 1));

    // Count enabled cycles, wrapping to zero at MODULO; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ce) begin
            cnt <= carry ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a one-byte holding register for gapless streaming.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = MIDI_CLKS_PER_BIT,
    parameter int unsigned CLKS_PER_BIT_W = MIDI_CLKS_PER_BIT_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    uart_tx_if.slave bus,
    output logic     busy,
    output logic     do_line
);

    tx_state_t                 state;
    logic [7:0]                hold_q;
    logic [7:0]                shift_q;
    logic                      full;
    logic                      do_q;
    logic                      busy_q;
    logic [CLKS_PER_BIT_W-1:0] baud_cnt;
    logic                      bit_end;
    logic [2:0]                bit_cnt;
    logic                      bit_carry;
    logic                      accept;
    logic                      unload;
    logic                      unused_cnt_bits;

    assign accept  = ce & bus.dv & ~full;
    // Holding register drains at IDLE or at the end of a stop bit.
    assign unload  = ce & full & ((state == IDLE) | ((state == STOP) & bit_end));
    assign bus.rdy = ~full;
    assign busy    = busy_q;
    assign do_line = do_q;

    assign unused_cnt_bits = ^{baud_cnt, bit_cnt};

    up_cnt_mod #(
        .MODULO (CLKS_PER_BIT),
        .W      (CLKS_PER_BIT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .clr   (ce & ((state == IDLE) | unload)),
        .cnt   (baud_cnt),
        .carry (bit_end)
    );

    up_cnt_mod #(
        .MODULO (8),
        .W      (3)
    ) u_bits (
        .clk   (clk),
        .rst   (rst),
        .ce    ((state == DATA) & bit_end),
        .clr   (ce & (state != DATA)),
        .cnt   (bit_cnt),
        .carry (bit_carry)
    );

    // Holding register: accept wins over unload so a same-cycle pair keeps full set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full   <= 1'b0;
        end else begin
            if (accept) begin
                hold_q <= bus.pi;
            end
            if (accept) begin
                full <= 1'b1;
            end else if (unload) begin
                full <= 1'b0;
            end
        end
    end

    // Frame sequencer with registered line and busy outputs, one cycle behind the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            do_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (ce) begin
            busy_q <= (state != IDLE) | full;
            case (state)
                START:   do_q <= 1'b0;
                DATA:    do_q <= shift_q[0];
                default: do_q <= 1'b1;
            endcase
            case (state)
                IDLE: begin
                    if (full) begin
                        shift_q <= hold_q;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_carry) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (full) begin
                            shift_q <= hold_q;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; expected line levels are computed from the sent bytes.
module tb_uart_tx;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic ce;
    logic busy;
    logic do_line;
    int   nvec;
    int   nerr;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .CLKS_PER_BIT_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .bus     (bus.slave),
        .busy    (busy),
        .do_line (do_line)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line level of bit idx within an 8N1 frame of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx - 1];
    endfunction

    // Stream n bytes with ce high one cycle in div; optionally pulse a junk byte at cycle junk_j.
    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input int div, input int junk_j);
        logic [7:0] bytes [3];
        int   k;
        int   total;
        int   cc;
        int   p;
        logic exp_do;
        logic acc;
        bytes  = '{b0, b1, b2};
        k      = 0;
        total  = n * 10 * CPB * div + 3 * div + 12;
        bus.dv = 1'b1;
        bus.pi = b0;
        ce     = 1'b1;
        for (int j = 0; j <= total; j++) begin
            cc = (j + div - 1) / div;
            if (cc < 3 || (cc - 3) >= n * 10 * CPB) begin
                exp_do = 1'b1;
            end else begin
                p      = cc - 3;
                exp_do = frame_bit(bytes[p / (10 * CPB)], (p % (10 * CPB)) / CPB);
            end
            chk1("do", do_line, exp_do);
            chk1("busy", busy, (cc >= 2) && (cc <= n * 10 * CPB + 2));
            if (div == 1 && j == 2) chk1("rdy_after_unload", bus.rdy, 1'b1);
            if (n == 3 && j == 161) chk1("rdy_full_stop", bus.rdy, 1'b0);
            if (n == 3 && j == 162) chk1("rdy_stop_unload", bus.rdy, 1'b1);
            if (j == junk_j) begin
                bus.dv = 1'b1;
                bus.pi = 8'hFF;
                chk1("rdy_junk", bus.rdy, 1'b0);
            end
            acc = ce & bus.dv & bus.rdy;
            if (j == total) break;
            tick();
            if (j == junk_j) begin
                chk1("junk_ignored", acc, 1'b0);
                chk1("rdy_after_junk", bus.rdy, 1'b0);
                if (k >= n) bus.dv = 1'b0;
            end else if (acc) begin
                k++;
                chk1("rdy_after_accept", bus.rdy, 1'b0);
                if (k < n) bus.pi = bytes[k];
                else bus.dv = 1'b0;
            end
            ce = ((j + 1) % div) == 0;
        end
        bus.dv = 1'b0;
        ce     = 1'b1;
        chkn("accepts", k, n);
    endtask

    initial begin
        nvec   = 0;
        nerr   = 0;
        rst    = 1'b1;
        ce     = 1'b0;
        bus.dv = 1'b0;
        bus.pi = 8'h00;
        #2 rst = 1'b0;
        tick();
        tick();
        chk1("reset_do", do_line, 1'b1);
        chk1("reset_rdy", bus.rdy, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) tick();

        // Single byte.
        run_stream(8'hA5, 8'h00, 8'h00, 1, 1, -1);
        // Back-to-back stream with dv held high.
        run_stream(8'h90, 8'h3C, 8'h7F, 3, 1, -1);
        // Clock enable one cycle in three.
        run_stream(8'h01, 8'h00, 8'h00, 1, 3, -1);
        // Junk byte offered while the holding register is full.
        run_stream(8'h55, 8'h0F, 8'h00, 2, 1, 50);

        // Asynchronous reset in the middle of the data bits.
        bus.dv = 1'b1;
        bus.pi = 8'hA5;
        tick();
        bus.dv = 1'b0;
        repeat (39) tick();
        chk1("pre_reset_do", do_line, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk1("async_reset_do", do_line, 1'b1);
        chk1("async_reset_rdy", bus.rdy, 1'b1);
        chk1("async_reset_busy", busy, 1'b0);
        tick();
        rst = 1'b1;
        for (int j = 0; j < 40; j++) begin
            chk1("post_reset_do", do_line, 1'b1);
            chk1("post_reset_busy", busy, 1'b0);
            tick();
        end
        chk1("post_reset_rdy", bus.rdy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the synth's MIDI/UART link: accepts bytes over a valid/ready handshake and shifts them out as 8N1 frames (1 start, 8 data LSB first, 1 stop) at a fixed bit period. It is the transmit counterpart of the receiver and uses the same bit-period parameters, so both ends run at 31250 baud from the system clock. A one-byte holding register lets the next byte queue during a frame, so a stream goes out with no idle gap between frames.

## Interface
- CLKS_PER_BIT, 3200, clock-enabled cycles per bit (31250 baud for MIDI); must be ≥ 2
- CLKS_PER_BIT_W, 12, baud counter width; must satisfy 2^W ≥ CLKS_PER_BIT
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset: one clock; reset is asynchronous and active-low
- ce  in  1  clock enable; when low, all state, counters and outputs hold
- dv  in  1  input byte valid
- pi  in  8  input byte; sampled only on an accepted cycle
- rdy  out  1  holding register empty; byte accepted on the edge where ce & dv & rdy
- busy  out  1  frame in progress (state ≠ IDLE) or holding register full
- do  out  1  serial line; idle high

## Operation
- Holding register: `hold_q[7:0]` plus a `full` flag; rdy = ~full. Accept loads hold_q and sets full.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: do = 1. If full, move hold_q into shift register, clear full, go START.
- START: do = 0 for one bit period, then go DATA.
- DATA: do = shift_q[0]; at each bit end shift right and increment the 3-bit bit counter. After the 8th bit (counter carry), go STOP.
- STOP: do = 1 for one bit period. At bit end: if full, load the shift register, clear full and go START directly with no idle bit. Otherwise go IDLE.
- Accept and unload in the same cycle (full, IDLE or STOP end): the unload takes the old hold_q, the new byte loads hold_q, and full stays 1.
- Baud counter: modulo CLKS_PER_BIT, cleared in IDLE and on entry to START. Its carry marks bit end.
- Reset (async, any state): state = IDLE, full = 0, counters = 0, shift register = 0, do = 1, rdy = 1, busy = 0. Reset mid-frame truncates the frame; the line returns high immediately.
- dv with rdy low is ignored. The byte must be held by the source until accepted.

## Timing
- do is a register output; no combinational path from dv/pi to do.
- Accept at edge N, while idle and ce continuously high: full is visible at N+1, FSM leaves IDLE at N+1, and do falls at N+2.
- Each bit lasts exactly CLKS_PER_BIT ce-high cycles. A frame lasts 10·CLKS_PER_BIT.
- rdy rises one cycle after the holding register unloads into the shift register.
- With ce low, all timing stretches: only ce-high cycles count.
- Back-to-back: the start bit of frame k+1 begins on the cycle after the last stop-bit cycle of frame k.

## Structure
- Shared package: FSM state encoding (IDLE=3'b000, START=3'b001, DATA=3'b011, STOP=3'b100, matching the receiver's numbering where meaningful) and the MIDI constants CLKS_PER_BIT=3200 and CLKS_PER_BIT_W=12.
- Reuse the existing `up_cnt_mod` twice:
  - baud counter (MODULO=CLKS_PER_BIT);
  - bit counter (MODULO=8, ce = DATA & bit end, clr = state ≠ DATA).
- Shift register and holding register are local.

## Test plan
- Reset: CLKS_PER_BIT=16, hold rst low mid-DATA -> do=1, rdy=1, busy=0 immediately (asynchronous), with no further edges on do.
- Single byte 8'hA5, ce=1 -> do = 0, 1,0,1,0,0,1,0,1, 1, each level exactly 16 cycles; start bit begins 2 cycles after accept; busy falls after the stop bit.
- Back-to-back 8'h90, 8'h3C, 8'h7F with dv held high -> 30 contiguous bit periods with no idle cycle between frames; rdy low only while the holding register is full.
- Simultaneous accept and unload at the STOP end -> no byte lost or duplicated; the received sequence matches the sent sequence (check with loopback into uart_rx).
- ce toggling 1-of-3 cycles, byte 8'h01 -> each bit lasts 48 clk cycles; waveform otherwise identical.
- dv pulsed while rdy=0 -> byte ignored; rdy, busy and do unaffected.
